int_mult_pp_stage: RTL and testbench
====================================

// Module: int_mult_pp_stage
// PURPOSE
//  Front stage of the pipelined integer multiplier. Accepts operands over a valid/ready handshake,
//  converts signed operands to magnitudes and registers DATA_WIDTH partial-product rows for the
//  stage-1 adders. Generates per-stage enables for the adder tree (bubble-collapsing) and carries
//  valid + result-sign sidebands aligned with the tree's final sum.
// PARAMETERS
//  DATA_WIDTH  32                  operand width; power of two, >= 4
//  NUM_STAGES  $clog2(DATA_WIDTH)  adder-tree stages downstream of this block
// PORTS
//  clk        in   1                   clock
//  rst_n      in   1                   synchronous, active-low reset
//  in_valid   in   1                   operand pair valid
//  in_ready   out  1                   block can accept operands this cycle
//  op_a       in   DATA_WIDTH          multiplicand
//  op_b       in   DATA_WIDTH          multiplier
//  is_signed  in   1                   1: two's-complement operands; 0: unsigned
//  pp_rows    out  DATA_WIDTH**2       row i at [i*DATA_WIDTH +: DATA_WIDTH], weight 2^i
//  stage_en   out  NUM_STAGES          en for adder-tree stage s (bit s-1 drives stage s)
//  out_valid  out  1                   final tree-stage sum is valid
//  out_ready  in   1                   downstream (result stage) consumes final sum
//  out_neg    out  1                   product must be negated downstream; aligned with out_valid
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all valid bits, pp_rows, sign pipeline -> 0; in_ready=1 the
//    next cycle; out_valid=0, out_neg=0. Reset mid-operation drops all in-flight products.
//  - Occupancy vector vld[0..NUM_STAGES]: vld[0] = pp register, vld[s] = adder-stage s register.
//  - Load rule (combinational): load[NUM_STAGES] = ~vld[NUM_STAGES] | out_ready;
//    load[k] = ~vld[k] | load[k+1] for k < NUM_STAGES. in_ready = load[0]. stage_en[s-1] = load[s].
//  - On load[k]: vld[k] <= vld[k-1] (vld[-1] = in_valid); neg[k] <= neg[k-1]. Data moves with vld.
//  - Accept = in_valid & in_ready. On accept: mag_a = (is_signed & op_a[MSB]) ? -op_a : op_a,
//    same for b; pp row i <= mag_a & {DATA_WIDTH{mag_b[i]}}; neg[0] <= is_signed & (a_MSB ^ b_MSB).
//  - in_ready does not depend on in_valid.
//  - -2^(DATA_WIDTH-1) has magnitude 2^(DATA_WIDTH-1), which fits unsigned DATA_WIDTH bits; no
//    overflow. Zero product with neg=1 is legal (downstream negation of 0 yields 0).
//  - pp_rows hold their value when load[0]=0; they are don't-care when vld[0]=0 but must be stable.
//  - Latency: accept at cycle t -> out_valid at t+NUM_STAGES+1 with no stalls.
//  - Throughput: 1/cycle while out_ready=1. Bubbles collapse: an empty stage always loads,
//    even while the output is stalled.
//  - out_valid=1 & out_ready=0: final stage holds; out_neg and the sum are stable until consumed.
//    out_ready=1 while out_valid=0 is a no-op.
//  - Same-cycle accept and output consume with a full pipe: both take effect; no loss or duplicate.
// STRUCTURE
//  - Shared package int_mult_pkg: function clog2, per-stage width constants
//    (INPUT_CARRY_WIDTH / OUTPUT_CARRY_WIDTH formulas), pp-row index/slice macros.
//  - One sub-module: int_mult_pipe_ctrl (vld/neg shift chain, load chain, in_ready, stage_en,
//    out_valid). Magnitude conversion and the AND-array stay inline.
// TESTING (bench DATA_WIDTH=8, NUM_STAGES=3)
//  - Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after release,
//    pp_rows=0, no spurious product.
//  - Unsigned: a=8'd200, b=8'd3, is_signed=0 -> row0=row1=200, others 0; out_valid at t+4; out_neg=0.
//  - Signed: a=8'hF6(-10), b=8'd7, is_signed=1 -> rows from mag 10 & 7; out_neg=1.
//    a=8'h80, b=8'h80 -> mag 128 each, out_neg=0.
//  - Back-to-back: 16 random pairs with out_ready=1 -> one accept per cycle; 16 out_valid pulses
//    in order, each out_neg matching its operand pair.
//  - Backpressure: fill the pipe, hold out_ready=0 for 6 cycles -> in_ready=0 once 4 entries are
//    held; outputs stable. Release -> drain in order with no loss or duplicate.
//  - Bubble collapse: issue 1 op, idle 2 cycles, issue 1 op, out_ready=0 -> second op advances
//    until adjacent to the first; stage_en shows exactly those loads.

Source files
------------

// File: rtl/int_mult_pkg.sv
// Shared definitions for the pipelined integer multiplier: width helpers for the
// adder tree and slice macros for the flattened partial-product row bus.
`ifndef INT_MULT_PKG_SV
`define INT_MULT_PKG_SV

`define PP_ROW_LSB(idx, width) ((idx) * (width))
`define PP_ROW(bus, idx, width) bus[`PP_ROW_LSB(idx, width) +: (width)]

package int_mult_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Stage s sums 2^s weighted rows, so its sum needs DATA_WIDTH + 2^s bits.
  function automatic int output_carry_width(input int data_width, input int stage);
    return data_width + (32'sd1 <<< stage);
  endfunction

  function automatic int input_carry_width(input int data_width, input int stage);
    int width;
    if (stage <= 1) begin
      width = data_width;
    end else begin
      width = output_carry_width(data_width, stage - 1);
    end
    return width;
  endfunction

endpackage

`endif

// File: rtl/int_mult_pipe_ctrl.sv
// Occupancy/sign shift chain for the multiplier pipe: a stage loads whenever it is
// empty or its successor loads, so bubbles collapse even while the output stalls.
module int_mult_pipe_ctrl #(
  parameter int NUM_STAGES = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_neg,
  input  logic                  out_ready,
  output logic                  in_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  out_valid,
  output logic                  out_neg
);

  logic [NUM_STAGES:0] vld_r;
  logic [NUM_STAGES:0] neg_r;
  logic [NUM_STAGES:0] load_s;
  logic [NUM_STAGES:0] vld_prev_s;
  logic [NUM_STAGES:0] neg_prev_s;

  // Load chain ripples back from the output stage.
  always_comb begin
    load_s             = '0;
    load_s[NUM_STAGES] = ~vld_r[NUM_STAGES] | out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      load_s[k] = ~vld_r[k] | load_s[k + 1];
    end
  end

  assign vld_prev_s = {vld_r[NUM_STAGES-1:0], in_valid};
  assign neg_prev_s = {neg_r[NUM_STAGES-1:0], in_neg};

  // Occupancy and sign registers advance per-stage under their own load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
      neg_r <= '0;
    end else begin
      vld_r <= (load_s & vld_prev_s) | (~load_s & vld_r);
      neg_r <= (load_s & neg_prev_s) | (~load_s & neg_r);
    end
  end

  assign in_ready  = load_s[0];
  assign stage_en  = load_s[NUM_STAGES:1];
  assign out_valid = vld_r[NUM_STAGES];
  assign out_neg   = neg_r[NUM_STAGES];

endmodule

// File: rtl/int_mult_pp_stage.sv
// Multiplier front stage: sign-to-magnitude conversion and the registered AND-array
// of partial-product rows, plus pipe control for the downstream adder tree.
module int_mult_pp_stage
  import int_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_STAGES = clog2(DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            op_a,
  input  logic [DATA_WIDTH-1:0]            op_b,
  input  logic                             is_signed,
  output logic [DATA_WIDTH*DATA_WIDTH-1:0] pp_rows,
  output logic [NUM_STAGES-1:0]            stage_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_neg
);

  logic [DATA_WIDTH-1:0]            mag_a_s;
  logic [DATA_WIDTH-1:0]            mag_b_s;
  logic                             neg_in_s;
  logic                             accept_s;
  logic                             ready_s;
  logic [DATA_WIDTH*DATA_WIDTH-1:0] pp_next_s;
  logic [DATA_WIDTH*DATA_WIDTH-1:0] pp_rows_r;

  // Magnitudes; the most negative value maps onto 2^(DATA_WIDTH-1) without overflow.
  always_comb begin
    if (is_signed && op_a[DATA_WIDTH-1]) begin
      mag_a_s = -op_a;
    end else begin
      mag_a_s = op_a;
    end
    if (is_signed && op_b[DATA_WIDTH-1]) begin
      mag_b_s = -op_b;
    end else begin
      mag_b_s = op_b;
    end
  end

  // Row i is the multiplicand magnitude gated by multiplier bit i.
  always_comb begin
    pp_next_s = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      `PP_ROW(pp_next_s, i, DATA_WIDTH) = mag_a_s & {DATA_WIDTH{mag_b_s[i]}};
    end
  end

  // Bubbles carry a clear sign so an idle slot never looks negative.
  assign neg_in_s = in_valid & is_signed & (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
  assign accept_s = in_valid & ready_s;

  // Partial-product register captures only on accept, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pp_rows_r <= '0;
    end else if (accept_s) begin
      pp_rows_r <= pp_next_s;
    end else begin
      pp_rows_r <= pp_rows_r;
    end
  end

  int_mult_pipe_ctrl #(
    .NUM_STAGES (NUM_STAGES)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_neg    (neg_in_s),
    .out_ready (out_ready),
    .in_ready  (ready_s),
    .stage_en  (stage_en),
    .out_valid (out_valid),
    .out_neg   (out_neg)
  );

  assign in_ready = ready_s;
  assign pp_rows  = pp_rows_r;

endmodule

// File: tb/tb_int_mult_pp_stage.sv
// Self-checking bench for int_mult_pp_stage (DATA_WIDTH=8, NUM_STAGES=3) against an
// arithmetic reference model and an in-flight product queue.
module tb_int_mult_pp_stage;

  localparam int W = 8;
  localparam int N = 3;
  localparam int D = N + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          is_signed;
  logic [W*W-1:0] pp_rows;
  logic [N-1:0]  stage_en;
  logic          out_valid;
  logic          out_ready;
  logic          out_neg;

  int_mult_pp_stage #(.DATA_WIDTH(W), .NUM_STAGES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .is_signed (is_signed),
    .pp_rows   (pp_rows),
    .stage_en  (stage_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic neg;
    int   t;
  } ent_t;

  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_leave = -100;
  int          n_out = 0;
  logic        pend = 1'b0;
  logic [63:0] pend_rows;
  int          pend_prod;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: magnitudes from signed/unsigned integer values, rows from multiplier bits.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [63:0] rows, output int prod, output logic neg);
    int ia, ib, ma, mb;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    ma = (ia < 0) ? -ia : ia;
    mb = (ib < 0) ? -ib : ib;
    rows = 64'd0;
    for (int i = 0; i < W; i++) begin
      if (((mb >> i) & 1) == 1) rows[i*W +: W] = ma[W-1:0];
    end
    prod = ma * mb;
    neg = (ia < 0) != (ib < 0);
  endtask

  function automatic int rows_sum(input logic [63:0] rows);
    int sum;
    sum = 0;
    for (int i = 0; i < W; i++) sum += int'(rows[i*W +: W]) << i;
    return sum;
  endfunction

  // One clock cycle: check outputs against the model, then advance it.
  task automatic cycle();
    logic        exp_ov;
    int          ready_at;
    logic        acc;
    logic        con;
    logic [63:0] r;
    int          p;
    logic        ng;
    #1;
    exp_ov = 1'b0;
    if (q.size() > 0) begin
      ready_at = q[0].t + D;
      if (last_leave + 1 > ready_at) ready_at = last_leave + 1;
      exp_ov = (cyc >= ready_at);
    end
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) check("out_neg", 64'(out_neg), 64'(q[0].neg));
    check("in_ready", 64'(in_ready), 64'((q.size() < D) || out_ready));
    acc = in_valid & in_ready;
    con = out_valid & out_ready;
    if (con && q.size() > 0) begin
      void'(q.pop_front());
      last_leave = cyc;
      n_out++;
    end
    if (acc) begin
      ref_model(op_a, op_b, is_signed, r, p, ng);
      q.push_back('{neg: ng, t: cyc});
      pend = 1'b1;
      pend_rows = r;
      pend_prod = p;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pend) begin
      check("pp_rows", 64'(pp_rows), pend_rows);
      check("pp_sum", 64'(rows_sum(64'(pp_rows))), 64'(pend_prod));
      pend = 1'b0;
    end
  endtask

  task automatic drive_rand();
    op_a      = W'($urandom);
    op_b      = W'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    is_signed = s;
    cycle();
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int          lat;
    int          out_mark;
    logic [2:0]  exp_en [8];

    // Reset held for two cycles with a pending request.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op_a      = 8'd55;
    op_b      = 8'd77;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_neg", 64'(out_neg), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pp_rows", 64'(pp_rows), 64'd0);
    q.delete();
    cyc = 0;
    idle(5);

    // Unsigned 200 * 3 with latency measurement.
    issue(8'd200, 8'd3, 1'b0);
    check("unsigned_rows", 64'(pp_rows), 64'h0000_0000_0000_C8C8);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      cycle();
      lat++;
    end
    check("unsigned_latency", 64'(lat), 64'(D));
    check("unsigned_neg", 64'(out_neg), 64'd0);
    idle(3);

    // Signed -10 * 7 and -128 * -128.
    issue(8'hF6, 8'd7, 1'b1);
    check("signed_rows", 64'(pp_rows), 64'h0000_0000_000A_0A0A);
    issue(8'h80, 8'h80, 1'b1);
    check("minneg_rows", 64'(pp_rows), 64'h8000_0000_0000_0000);
    idle(6);

    // Back-to-back stream.
    out_mark = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      cycle();
    end
    idle(8);
    check("b2b_count", 64'(n_out - out_mark), 64'd16);

    // Backpressure: fill while stalled, then simultaneous accept/consume, then drain.
    out_mark  = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      cycle();
    end
    #1;
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_full_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      cycle();
    end
    idle(10);
    check("bp_count", 64'(n_out - out_mark), 64'd8);

    // Bubble collapse with the output stalled.
    exp_en[0] = 3'b111; exp_en[1] = 3'b111; exp_en[2] = 3'b111; exp_en[3] = 3'b111;
    exp_en[4] = 3'b011; exp_en[5] = 3'b011; exp_en[6] = 3'b001; exp_en[7] = 3'b001;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0 || c == 3);
      op_a      = 8'(c + 9);
      op_b      = 8'h85;
      is_signed = 1'b1;
      #1;
      check($sformatf("bubble_stage_en_c%0d", c), 64'(stage_en), 64'(exp_en[c]));
      cycle();
    end
    out_ready = 1'b1;
    idle(8);

    // Random mixed traffic.
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      cycle();
    end
    out_ready = 1'b1;
    idle(10);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
